// File: rtl/issue_ctrl.sv
// issue_ctrl: issue-stage sequencer. It pops the instruction queue, latches the head word into IR,
// and issues it to the lowest free reservation station of its class. Define ISSUE_STATS_EN for the n_issued/n_stall counters.
module issue_ctrl #(
  parameter int N_ADD = 3,
  parameter int N_MUL = 2,
  parameter int N_LD  = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             q_vazio,
  input  logic             q_adc,
  output logic             q_rtr,
  input  logic [15:0]      q_instr,
  input  logic [N_ADD-1:0] busy_add,
  input  logic [N_MUL-1:0] busy_mul,
  input  logic [N_LD-1:0]  busy_ld,
  input  logic             hold,
  output logic             iss_valid,
  output logic [1:0]       iss_class,
  output logic [1:0]       iss_slot,
  output logic [15:0]      iss_instr,
  output logic             err_op,
  output logic             ocupado
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]      n_issued,
  output logic [15:0]      n_stall
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] POP   = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;

  logic [1:0]  state_reg, state_next;
  logic [15:0] ir_reg, ir_next;

  // Busy vectors widened to 4 bits; slots that do not exist read as busy.
  logic [3:0] add_pad, mul_pad, ld_pad;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < N_ADD) begin : g_add
        assign add_pad[gi] = busy_add[gi];
      end else begin : g_add_none
        assign add_pad[gi] = 1'b1;
      end
      if (gi < N_MUL) begin : g_mul
        assign mul_pad[gi] = busy_mul[gi];
      end else begin : g_mul_none
        assign mul_pad[gi] = 1'b1;
      end
      if (gi < N_LD) begin : g_ld
        assign ld_pad[gi] = busy_ld[gi];
      end else begin : g_ld_none
        assign ld_pad[gi] = 1'b1;
      end
    end
  endgenerate

  function automatic logic [1:0] lowest_free(input logic [3:0] b);
    lowest_free = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!b[i]) lowest_free = i[1:0];
    end
  endfunction

  logic [3:0] op;
  logic       op_legal;
  logic [1:0] op_class;
  logic [3:0] class_busy;
  logic       slot_free;
  logic [1:0] slot_sel;
  logic       in_issue;
  logic       issue_fire;

  // Legal opcodes 0..5 map to class op[2:1]: 00 add, 01 mul, 10 load/store.
  assign op       = ir_reg[15:12];
  assign op_legal = (op <= 4'd5);
  assign op_class = op[2:1];

  always_comb begin
    class_busy = ld_pad;
    case (op_class)
      CLS_ADD: class_busy = add_pad;
      CLS_MUL: class_busy = mul_pad;
      default: class_busy = ld_pad;
    endcase
  end

  assign slot_free  = ~&class_busy;
  assign slot_sel   = lowest_free(class_busy);
  assign in_issue   = (state_reg == ISSUE);
  assign issue_fire = in_issue && op_legal && slot_free && !hold;

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    case (state_reg)
      IDLE:  if (!q_vazio) state_next = POP;
      // A simultaneous add wins inside the queue, so the remove must be retried.
      POP:   state_next = q_adc ? POP : LATCH;
      LATCH: begin
        ir_next    = q_instr;
        state_next = ISSUE;
      end
      ISSUE: if (!op_legal || issue_fire) state_next = q_vazio ? IDLE : POP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= IDLE;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  assign q_rtr     = (state_reg == POP);
  assign ocupado   = (state_reg != IDLE);
  assign iss_valid = issue_fire;
  assign err_op    = in_issue && !op_legal;
  assign iss_instr = in_issue ? ir_reg : 16'h0000;
  assign iss_class = (in_issue && op_legal) ? op_class : 2'd0;
  assign iss_slot  = (in_issue && op_legal) ? slot_sel : 2'd0;

`ifdef ISSUE_STATS_EN
  logic [15:0] n_issued_reg, n_stall_reg;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      n_issued_reg <= 16'h0000;
      n_stall_reg  <= 16'h0000;
    end else begin
      if (issue_fire) n_issued_reg <= n_issued_reg + 16'd1;
      if (in_issue && op_legal && !issue_fire) n_stall_reg <= n_stall_reg + 16'd1;
    end
  end

  assign n_issued = n_issued_reg;
  assign n_stall  = n_stall_reg;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed timing scenarios plus a randomized run scored against an in-order issue model.
// The bench contains a behavioural instruction queue. Define ISSUE_STATS_EN to exercise the counters.
module tb_issue_ctrl;
  localparam int N_ADD = 3;
  localparam int N_MUL = 2;
  localparam int N_LD  = 2;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic q_vazio = 1'b1;
  logic q_adc = 1'b0;
  logic hold = 1'b0;
  logic [15:0] q_instr = 16'h0000;
  logic [15:0] add_word = 16'h0000;
  logic [N_ADD-1:0] busy_add = '0;
  logic [N_MUL-1:0] busy_mul = '0;
  logic [N_LD-1:0]  busy_ld = '0;
  logic q_rtr, iss_valid, err_op, ocupado;
  logic [1:0] iss_class, iss_slot;
  logic [15:0] iss_instr;
`ifdef ISSUE_STATS_EN
  logic [15:0] n_issued, n_stall;
`endif

  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] fifo[$];

  issue_ctrl #(.N_ADD(N_ADD), .N_MUL(N_MUL), .N_LD(N_LD)) dut (
    .CLK(CLK), .CLR(CLR), .q_vazio(q_vazio), .q_adc(q_adc), .q_rtr(q_rtr),
    .q_instr(q_instr), .busy_add(busy_add), .busy_mul(busy_mul), .busy_ld(busy_ld),
    .hold(hold), .iss_valid(iss_valid), .iss_class(iss_class), .iss_slot(iss_slot),
    .iss_instr(iss_instr), .err_op(err_op), .ocupado(ocupado)
`ifdef ISSUE_STATS_EN
    , .n_issued(n_issued), .n_stall(n_stall)
`endif
  );

  always #5 CLK = ~CLK;

  // Queue model: add has priority over remove; the word appears the cycle after an accepted remove.
  always @(posedge CLK) begin
    if (CLR) fifo.delete();
    else if (q_adc) begin
      if (fifo.size() < 8) fifo.push_back(add_word);
    end else if (q_rtr && fifo.size() != 0) q_instr <= fifo.pop_front();
    q_vazio <= (fifo.size() == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int cls_of(input logic [15:0] w);
    int op;
    op = int'(w[15:12]);
    if (op < 2) return 0;
    if (op < 4) return 1;
    if (op < 6) return 2;
    return -1;
  endfunction

  function automatic int first_free(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) if (b[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    cyc();
    CLR = 1'b1; q_adc = 1'b0; hold = 1'b0;
    busy_add = '0; busy_mul = '0; busy_ld = '0;
    cyc();
    cyc();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    CLR = 1'b1;
    cyc();
    #1;
    n_tests++;
    if ({q_rtr, iss_valid, err_op, ocupado} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {q_rtr, iss_valid, err_op, ocupado});
    end
    n_tests++;
    if ({iss_class, iss_slot, iss_instr} !== 20'h00000) begin
      n_fail++; $display("FAIL reset_fields: got %h expected 00000", {iss_class, iss_slot, iss_instr});
    end
    CLR = 1'b0;
  endtask

  task automatic test_add_latency();
    logic e;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      cyc();
      q_adc = (k == 0); add_word = 16'h0123;
      #1;
      e = (k == 2);
      n_tests++;
      if (q_rtr !== e) begin n_fail++; $display("FAIL add_rtr k=%0d: got %b expected %b", k, q_rtr, e); end
      e = (k == 4);
      n_tests++;
      if (iss_valid !== e) begin n_fail++; $display("FAIL add_valid k=%0d: got %b expected %b", k, iss_valid, e); end
      e = (k >= 2 && k <= 4);
      n_tests++;
      if (ocupado !== e) begin n_fail++; $display("FAIL add_ocupado k=%0d: got %b expected %b", k, ocupado, e); end
      if (k == 4) begin
        n_tests++;
        if ({iss_class, iss_slot, iss_instr} !== {2'd0, 2'd0, 16'h0123}) begin
          n_fail++; $display("FAIL add_fields: got cls=%0d slot=%0d instr=%h expected 0 0 0123", iss_class, iss_slot, iss_instr);
        end
      end
    end
  endtask

  task automatic test_mul_stall();
    logic e;
    do_reset();
    for (int k = 0; k <= 13; k++) begin
      cyc();
      q_adc = (k <= 1); add_word = (k == 0) ? 16'h2456 : 16'h3789;
      busy_mul = (k < 7) ? 2'b01 : (k <= 11) ? 2'b11 : 2'b10;
      #1;
      e = (k == 4 || k == 12);
      n_tests++;
      if (iss_valid !== e) begin n_fail++; $display("FAIL mul_valid k=%0d: got %b expected %b", k, iss_valid, e); end
      if (k == 4) begin
        n_tests++;
        if ({iss_class, iss_slot, iss_instr} !== {2'd1, 2'd1, 16'h2456}) begin
          n_fail++; $display("FAIL mul_first: got cls=%0d slot=%0d instr=%h expected 1 1 2456", iss_class, iss_slot, iss_instr);
        end
      end
      if (k >= 7 && k <= 11) begin
        n_tests++;
        if (iss_instr !== 16'h3789 || ocupado !== 1'b1) begin
          n_fail++; $display("FAIL mul_hold k=%0d: got instr=%h ocupado=%b expected 3789 1", k, iss_instr, ocupado);
        end
      end
      if (k == 12) begin
        n_tests++;
        if ({iss_class, iss_slot, iss_instr} !== {2'd1, 2'd0, 16'h3789}) begin
          n_fail++; $display("FAIL mul_release: got cls=%0d slot=%0d instr=%h expected 1 0 3789", iss_class, iss_slot, iss_instr);
        end
      end
    end
  endtask

  task automatic test_retry();
    logic e;
    int n_v;
    n_v = 0;
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      cyc();
      q_adc = (k == 0 || k == 2); add_word = (k == 0) ? 16'h0ABC : 16'h1DEF;
      #1;
      e = (k == 2 || k == 3 || k == 6);
      n_tests++;
      if (q_rtr !== e) begin n_fail++; $display("FAIL retry_rtr k=%0d: got %b expected %b", k, q_rtr, e); end
      if (iss_valid === 1'b1) n_v++;
      if (k == 5 || k == 8) begin
        n_tests++;
        if (iss_valid !== 1'b1 || iss_instr !== ((k == 5) ? 16'h0ABC : 16'h1DEF)) begin
          n_fail++; $display("FAIL retry_issue k=%0d: got valid=%b instr=%h expected 1 %h", k, iss_valid, iss_instr,
                             (k == 5) ? 16'h0ABC : 16'h1DEF);
        end
      end
    end
    n_tests++;
    if (n_v != 2) begin n_fail++; $display("FAIL retry_count: got %0d issues expected 2", n_v); end
  endtask

  task automatic test_illegal();
    logic e;
    do_reset();
    busy_ld = 2'b01;
    for (int k = 0; k <= 8; k++) begin
      cyc();
      q_adc = (k <= 1); add_word = (k == 0) ? 16'h7000 : 16'h4321;
      #1;
      e = (k == 4);
      n_tests++;
      if (err_op !== e) begin n_fail++; $display("FAIL ill_err k=%0d: got %b expected %b", k, err_op, e); end
      e = (k == 7);
      n_tests++;
      if (iss_valid !== e) begin n_fail++; $display("FAIL ill_valid k=%0d: got %b expected %b", k, iss_valid, e); end
      if (k == 7) begin
        n_tests++;
        if ({iss_class, iss_slot, iss_instr} !== {2'd2, 2'd1, 16'h4321}) begin
          n_fail++; $display("FAIL ill_ld: got cls=%0d slot=%0d instr=%h expected 2 1 4321", iss_class, iss_slot, iss_instr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [15:0] words [3];
    words[0] = 16'h0001; words[1] = 16'h1002; words[2] = 16'h0003;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      cyc();
      q_adc = (k <= 2); add_word = (k <= 2) ? words[k] : 16'h0000;
      #1;
      e = (k == 5 || k == 8 || k == 11);
      n_tests++;
      if (iss_valid !== e) begin n_fail++; $display("FAIL b2b_valid k=%0d: got %b expected %b", k, iss_valid, e); end
      if (e) begin
        n_tests++;
        if ({iss_class, iss_slot, iss_instr} !== {2'd0, 2'd0, words[(k - 5) / 3]}) begin
          n_fail++; $display("FAIL b2b_fields k=%0d: got cls=%0d slot=%0d instr=%h expected 0 0 %h", k, iss_class, iss_slot,
                             iss_instr, words[(k - 5) / 3]);
        end
      end
    end
  endtask

  task automatic test_clr_latch();
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      cyc();
      q_adc = (k == 0); add_word = 16'h0555;
      CLR = (k == 3);
      #1;
      if (k == 3) begin
        n_tests++;
        if (ocupado !== 1'b1 || q_rtr !== 1'b0) begin
          n_fail++; $display("FAIL clr_latch_state: got ocupado=%b rtr=%b expected 1 0", ocupado, q_rtr);
        end
      end
      if (k >= 4) begin
        n_tests++;
        if ({q_rtr, iss_valid, err_op, ocupado, iss_class, iss_slot, iss_instr} !== 24'h000000) begin
          n_fail++; $display("FAIL clr_latch_out k=%0d: got %h expected 000000", k,
                             {q_rtr, iss_valid, err_op, ocupado, iss_class, iss_slot, iss_instr});
        end
      end
    end
  endtask

`ifdef ISSUE_STATS_EN
  task automatic test_stats();
    logic e;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      cyc();
      q_adc = (k <= 1); add_word = (k == 0) ? 16'h0011 : 16'h1022;
      hold = (k == 4 || k == 5);
      busy_add = (k == 9 || k == 10) ? 3'b111 : 3'b000;
      #1;
      if (k == 0) begin
        n_tests++;
        if (n_issued !== 16'd0 || n_stall !== 16'd0) begin
          n_fail++; $display("FAIL stats_reset: got %0d %0d expected 0 0", n_issued, n_stall);
        end
      end
      e = (k == 6 || k == 11);
      n_tests++;
      if (iss_valid !== e) begin n_fail++; $display("FAIL stats_valid k=%0d: got %b expected %b", k, iss_valid, e); end
    end
    n_tests++;
    if (n_issued !== 16'd2 || n_stall !== 16'd4) begin
      n_fail++; $display("FAIL stats_count: got issued=%0d stall=%0d expected 2 4", n_issued, n_stall);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] sent[$];
    logic [15:0] w;
    int pushed, cyc_cnt, c, s;
    logic [3:0] cb;
    int nb;
    pushed = 0; cyc_cnt = 0;
    do_reset();
    while ((pushed < 40 || sent.size() != 0) && cyc_cnt < 5000) begin
      cyc();
      if (pushed < 40 && fifo.size() < 6 && $urandom_range(0, 2) == 0) begin
        w = {4'($urandom_range(0, 8)), 12'($urandom_range(1, 4095))};
        q_adc = 1'b1; add_word = w; sent.push_back(w); pushed++;
      end else q_adc = 1'b0;
      hold = ($urandom_range(0, 3) == 0);
      busy_add = 3'($urandom); busy_mul = 2'($urandom); busy_ld = 2'($urandom);
      #1;
      cyc_cnt++;
      if (q_rtr === 1'b1) begin
        n_tests++;
        if (q_vazio !== 1'b0) begin n_fail++; $display("FAIL rnd_pop_empty: got q_vazio=%b expected 0", q_vazio); end
      end
      if (sent.size() == 0) begin
        if (iss_valid === 1'b1 || err_op === 1'b1) begin
          n_tests++; n_fail++;
          $display("FAIL rnd_spurious: got valid=%b err=%b expected 0 0", iss_valid, err_op);
        end
        continue;
      end
      c = cls_of(sent[0]);
      cb = (c == 0) ? 4'(busy_add) : (c == 1) ? 4'(busy_mul) : 4'(busy_ld);
      nb = (c == 0) ? N_ADD : (c == 1) ? N_MUL : N_LD;
      s = first_free(cb, nb);
      if (iss_valid === 1'b1) begin
        n_tests++;
        if (c < 0 || hold !== 1'b0 || s < 0 || iss_instr !== sent[0] || iss_class !== 2'(c) || iss_slot !== 2'(s)) begin
          n_fail++;
          $display("FAIL rnd_issue: got instr=%h cls=%0d slot=%0d expected instr=%h cls=%0d slot=%0d (hold=%b)",
                   iss_instr, iss_class, iss_slot, sent[0], c, s, hold);
        end
        void'(sent.pop_front());
      end else if (err_op === 1'b1) begin
        n_tests++;
        if (c >= 0) begin n_fail++; $display("FAIL rnd_err: got err for %h expected legal issue", sent[0]); end
        void'(sent.pop_front());
      end else if (c >= 0 && ocupado === 1'b1 && iss_instr === sent[0]) begin
        n_tests++;
        if (hold === 1'b0 && s >= 0) begin
          n_fail++; $display("FAIL rnd_missed: got valid=0 for %h expected 1 (slot %0d free)", sent[0], s);
        end
      end
    end
    n_tests++;
    if (sent.size() != 0) begin
      n_fail++; $display("FAIL rnd_timeout: got %0d words outstanding expected 0", sent.size());
    end
    q_adc = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_mul_stall();
    test_retry();
    test_illegal();
    test_back_to_back();
    test_clr_latch();
`ifdef ISSUE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
